// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: state encoding and default word width shared by the bit-serial adder datapath
package serial_arith_pkg;
  localparam int SERIAL_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;
endpackage

// File: rtl/serial_shift_reg.sv
// serial_shift_reg: WIDTH-bit right shift register (MSB-in) with clear and enable; exposes its next value
module serial_shift_reg
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             din_i,
  output logic [WIDTH-1:0] next_o
);
  logic [WIDTH-1:0] sr_q, sr_d, base;
  // clear and shift together load din as the first bit of a fresh word
  always_comb begin
    base = clr_i ? '0 : sr_q;
    sr_d = en_i ? {din_i, base[WIDTH-1:1]} : base;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) sr_q <= '0;
    else sr_q <= sr_d;
  assign next_o = sr_d;
endmodule

// File: rtl/serial_sum_collector.sv
// serial_sum_collector: assembles an LSB-first serial sum plus final carry into a word on a valid/ready handshake
// Optional parity output enabled by defining SERIAL_SUM_COLLECTOR_PARITY_EN.
module serial_sum_collector
  import serial_arith_pkg::*;
#(
  parameter  int WIDTH = SERIAL_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             sum_bit,
  input  logic             cout_bit,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy,
  output logic             overrun
`ifdef SERIAL_SUM_COLLECTOR_PARITY_EN
  , output logic           parity
`endif
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q, sr_next;
  logic             carry_q, valid_q, busy_q, ovr_q;
  logic             in_shift, in_hold, hs, restart, take, last;
  assign in_shift = state_q == SHIFT;
  assign in_hold  = state_q == HOLD;
  assign hs       = in_hold & res_ready;
  // start is honoured everywhere except in HOLD without an accepted transfer
  assign restart  = start & (state_q == IDLE | in_shift | hs);
  assign take     = in_shift & bit_valid;
  assign last     = take & ~start & (cnt_q == CNT_W'(WIDTH - 1));
  assign state_d  = restart ? SHIFT : last ? HOLD : hs ? IDLE : state_q;
  serial_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (restart),
    .en_i   (take),
    .din_i  (sum_bit),
    .next_o (sr_next)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= state_d == HOLD;
      busy_q  <= state_d == SHIFT;
      ovr_q   <= (ovr_q & ~restart) | (in_hold & bit_valid);
      if (restart) cnt_q <= CNT_W'(take);
      else if (take) cnt_q <= cnt_q + 1'b1;
      if (last) begin
        result_q <= sr_next;
        carry_q  <= cout_bit;
      end
    end
  assign res_valid = valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;
`ifdef SERIAL_SUM_COLLECTOR_PARITY_EN
  logic par_acc_q, par_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      par_acc_q <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      if (restart) par_acc_q <= take & sum_bit;
      else if (take) par_acc_q <= par_acc_q ^ sum_bit;
      if (last) par_q <= par_acc_q ^ sum_bit ^ cout_bit;
    end
  assign parity = par_q;
`endif
endmodule

// File: tb/tb_serial_sum_collector.sv
// tb_serial_sum_collector: randomized scoreboard bench for serial_sum_collector
module tb_serial_sum_collector;
  localparam int W = 8;
  logic clk = 0, rst = 0, start = 0, bit_valid = 0, sum_bit = 0, cout_bit = 0, res_ready = 0;
  logic res_valid, carry_out, busy, overrun;
  logic [W-1:0] result;
`ifdef SERIAL_SUM_COLLECTOR_PARITY_EN
  logic parity;
`endif
  int n_cmp = 0, n_err = 0;
  logic [W:0] exp_q[$];

  serial_sum_collector #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .sum_bit   (sum_bit),
    .cout_bit  (cout_bit),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .carry_out (carry_out),
    .busy      (busy),
    .overrun   (overrun)
`ifdef SERIAL_SUM_COLLECTOR_PARITY_EN
    , .parity  (parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // a full word of n==W bits is pushed to the scoreboard as {carry, word}
  task automatic send_bits(input logic [W-1:0] w, input logic c, input int n, input int gap_at,
                           input int gap_len, input bit rnd, input bit ws);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (i == gap_at) ? gap_len : ((rnd && i > 0) ? int'($urandom_range(0, 1)) : 0);
      start = 0;
      bit_valid = 0;
      repeat (g) begin
        tick();
        check("busy_gap", busy, 1);
      end
      bit_valid = 1;
      sum_bit = w[i];
      cout_bit = (i == n - 1) ? c : 1'($urandom);
      start = ws && i == 0;
      if (i == W - 1) exp_q.push_back({c, w});
      tick();
    end
    bit_valid = 0;
    start = 0;
    sum_bit = 0;
    cout_bit = 0;
  endtask

  task automatic accept();
    int k;
    k = 0;
    while (!res_valid && k < 20) begin
      tick();
      k++;
    end
    if (!res_valid) check("valid_timeout", res_valid, 1);
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask

  always @(negedge clk) begin : monitor
    logic [W:0] e;
    if (rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) check("unexpected_word", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("result", result, e[W-1:0]);
        check("carry_out", carry_out, e[W]);
`ifdef SERIAL_SUM_COLLECTOR_PARITY_EN
        check("parity", parity, ^e);
`endif
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit b2b, hs, ws, pulsed;
    int k;
    logic [W-1:0] w;
    logic c;
    #12;
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    tick();
    rst = 1;
    tick();
    do_start();
    check("busy_start", busy, 1);
    send_bits(8'h5A, 1, W, -1, 0, 0, 0);
    check("latency_valid", res_valid, 1);
    check("busy_hold", busy, 0);
    check("result_5a", result, 8'h5A);
`ifdef SERIAL_SUM_COLLECTOR_PARITY_EN
    check("parity_5a", parity, 1);
`endif
    bit_valid = 1;
    sum_bit = 1;
    tick();
    bit_valid = 0;
    repeat (4) tick();
    check("hold_result", result, 8'h5A);
    check("hold_valid", res_valid, 1);
    check("overrun_set", overrun, 1);
    start = 1;
    tick();
    check("start_ignored_valid", res_valid, 1);
    check("start_ignored_ovr", overrun, 1);
    res_ready = 1;
    tick();
    start = 0;
    res_ready = 0;
    check("overrun_clr", overrun, 0);
    check("b2b_busy", busy, 1);
    check("b2b_valid", res_valid, 0);
    send_bits(8'hFF, 0, W, -1, 0, 0, 0);
    check("b2b_latency", res_valid, 1);
    accept();
    do_start();
    send_bits(8'hC3, 1, W, 3, 2, 0, 0);
    accept();
    do_start();
    send_bits(8'h0F, 0, 4, -1, 0, 0, 0);
    check("partial_hidden", result, 8'hC3);
    do_start();
    send_bits(8'hA5, 1, W, -1, 0, 0, 0);
    accept();
    do_start();
    send_bits(8'h33, 0, 3, -1, 0, 0, 0);
    send_bits(8'h6C, 1, W, -1, 0, 0, 1);
    accept();
    do_start();
    send_bits(8'h77, 1, 5, -1, 0, 0, 0);
    rst = 0;
    #2;
    check("arst_shift_busy", busy, 0);
    check("arst_shift_result", result, 0);
    check("arst_shift_carry", carry_out, 0);
    tick();
    rst = 1;
    tick();
    do_start();
    send_bits(8'h99, 1, W, -1, 0, 0, 0);
    check("pre_arst_valid", res_valid, 1);
    rst = 0;
    #2;
    check("arst_hold_valid", res_valid, 0);
    check("arst_hold_result", result, 0);
    check("arst_hold_carry", carry_out, 0);
    exp_q.delete();
    tick();
    rst = 1;
    tick();
    do_start();
    send_bits(8'h3E, 0, W, -1, 0, 0, 0);
    accept();
    b2b = 0;
    for (int n = 0; n < 40; n++) begin
      if (!b2b) do_start();
      ws = 0;
      if ($urandom_range(0, 4) == 0) begin
        send_bits(W'($urandom), 0, $urandom_range(1, W - 1), -1, 0, 1, 0);
        ws = 1'($urandom);
        if (!ws) do_start();
      end
      w = W'($urandom);
      c = 1'($urandom);
      send_bits(w, c, W, -1, 0, 1, ws);
      hs = 0;
      pulsed = 0;
      k = 0;
      while (!hs && k < 40) begin
        res_ready = 1'($urandom);
        bit_valid = !res_ready && $urandom_range(0, 5) == 0;
        pulsed = pulsed | bit_valid;
        start = res_ready && $urandom_range(0, 1) == 1;
        hs = res_valid && res_ready;
        b2b = start && hs;
        tick();
        bit_valid = 0;
        start = 0;
        res_ready = 0;
        k++;
      end
      if (!hs) check("hs_timeout", hs, 1);
      if (b2b) check("rand_ovr_clr", overrun, 0);
      else if (pulsed) check("rand_ovr_set", overrun, 1);
    end
    if (b2b) begin
      send_bits(8'h81, 1, W, -1, 0, 0, 0);
      accept();
    end
    repeat (3) tick();
    check("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
